// File: rtl/fft_inplace_ctrl.sv
// rtl/fft_inplace_ctrl.sv - address/control sequencer for a two-bank in-place radix-2 FFT
//
// Purpose: loads N = 2^LOG2N samples into two N/2-deep banks (bank = parity of
// the sample index), sequences LOG2N-1 butterfly stages with delayed write-back
// (PIPE_LAT cycles), then unloads the N samples under out_ready backpressure.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_in_valid / o_in_ready     sample load handshake (ready only in LOAD)
//   i_inverse                   IFFT mode, latched on the last accepted sample
//   i_out_ready / o_out_valid   unload handshake
//   o_raddr_b*/o_re_b*          bank read address / enable
//   o_waddr_b*/o_we_b*          bank write address / enable
//   o_bank_select               load/unload mux steering (1 = bank1)
//   o_stage, o_tw_addr, o_tw_conj  butterfly stage, twiddle address, conjugate flag
//   o_input_done, o_output_start, o_done  phase status
module fft_inplace_ctrl #(
  parameter int LOG2N    = 6,
  parameter int PIPE_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic               i_inverse,
  input  logic               i_out_ready,
  output logic               o_out_valid,
  output logic [LOG2N-2:0]   o_raddr_b0,
  output logic [LOG2N-2:0]   o_raddr_b1,
  output logic [LOG2N-2:0]   o_waddr_b0,
  output logic [LOG2N-2:0]   o_waddr_b1,
  output logic               o_re_b0,
  output logic               o_re_b1,
  output logic               o_we_b0,
  output logic               o_we_b1,
  output logic               o_bank_select,
  output logic [3:0]         o_stage,
  output logic [LOG2N-2:0]   o_tw_addr,
  output logic               o_tw_conj,
  output logic               o_input_done,
  output logic               o_output_start,
  output logic               o_done
);
  localparam int A = LOG2N - 1;
  localparam int N = 1 << LOG2N;

  typedef enum logic [2:0] {S_LOAD, S_COMPUTE, S_GAP, S_FLUSH, S_UNLOAD} state_t;

  state_t           r_state, w_next;
  logic [LOG2N-1:0] r_k;
  logic [A-1:0]     r_j;
  logic [3:0]       r_s;
  logic [2:0]       r_lat;
  logic             r_tw_conj, r_input_done, r_output_start, r_done, r_out_valid;
  logic             r_rd_all;  // every unload read has issued; k parks at N-1
  logic [PIPE_LAT-1:0] r_dly_we;
  logic [A-1:0]     r_dly_a0 [PIPE_LAT];
  logic [A-1:0]     r_dly_a1 [PIPE_LAT];

  logic             w_par, w_accept, w_last_k, w_rd_en, w_issue, w_last_hs, w_dly_we;
  logic [3:0]       w_shift;
  logic [A-1:0]     w_stride, w_partner;

  assign w_par     = ^r_k;
  assign w_accept  = (r_state == S_LOAD) & i_in_valid;
  assign w_last_k  = (r_k == LOG2N'(N - 1));
  assign w_rd_en   = (r_state == S_COMPUTE);
  // Stage s pairs bank addresses differing in bit A-1-s; partner is j xor stride.
  assign w_shift   = 4'(A - 1) - r_s;
  assign w_stride  = A'(1) << w_shift;
  assign w_partner = ((r_j & w_stride) != '0) ? (r_j - w_stride) : (r_j + w_stride);
  assign w_issue   = (r_state == S_UNLOAD) & ~r_rd_all & (~r_out_valid | i_out_ready);
  assign w_last_hs = (r_state == S_UNLOAD) & r_rd_all & r_out_valid & i_out_ready;
  assign w_dly_we  = r_dly_we[PIPE_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    o_in_ready    = 1'b0;
    o_re_b0       = 1'b0;
    o_re_b1       = 1'b0;
    o_raddr_b0    = '0;
    o_raddr_b1    = '0;
    o_bank_select = 1'b0;
    o_tw_addr     = '0;
    // Delayed butterfly write-back runs across COMPUTE, GAP and FLUSH.
    o_we_b0       = w_dly_we;
    o_we_b1       = w_dly_we;
    o_waddr_b0    = w_dly_we ? r_dly_a0[PIPE_LAT-1] : '0;
    o_waddr_b1    = w_dly_we ? r_dly_a1[PIPE_LAT-1] : '0;
    case (r_state)
      S_LOAD: begin
        o_in_ready = 1'b1;
        if (w_accept) begin
          o_bank_select = w_par;
          o_we_b0       = ~w_par;
          o_we_b1       = w_par;
          o_waddr_b0    = r_k[LOG2N-1:1];
          o_waddr_b1    = r_k[LOG2N-1:1];
          if (w_last_k) w_next = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        o_re_b0    = 1'b1;
        o_re_b1    = 1'b1;
        o_raddr_b0 = r_j;
        o_raddr_b1 = w_partner;
        o_tw_addr  = (r_j & (w_stride - A'(1))) << r_s;
        if (r_j == {A{1'b1}})
          w_next = (r_s == 4'(LOG2N - 2)) ? S_FLUSH : S_GAP;
      end
      S_GAP: begin
        if (r_lat == 3'(PIPE_LAT - 1)) w_next = S_COMPUTE;
      end
      S_FLUSH: begin
        if (r_lat == 3'(PIPE_LAT - 1)) w_next = S_UNLOAD;
      end
      S_UNLOAD: begin
        o_raddr_b0    = r_k[LOG2N-1:1];
        o_raddr_b1    = r_k[LOG2N-1:1];
        o_bank_select = w_par;
        o_re_b0       = w_issue & ~w_par;
        o_re_b1       = w_issue & w_par;
        if (w_last_hs) w_next = S_LOAD;
      end
      default: w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k            <= '0;
      r_j            <= '0;
      r_s            <= '0;
      r_lat          <= '0;
      r_tw_conj      <= 1'b0;
      r_input_done   <= 1'b0;
      r_output_start <= 1'b0;
      r_done         <= 1'b0;
      r_out_valid    <= 1'b0;
      r_rd_all       <= 1'b0;
      r_dly_we       <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_dly_a0[i] <= '0;
        r_dly_a1[i] <= '0;
      end
    end else begin
      r_done <= w_last_hs;
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        r_dly_we[i] <= r_dly_we[i-1];
        r_dly_a0[i] <= r_dly_a0[i-1];
        r_dly_a1[i] <= r_dly_a1[i-1];
      end
      r_dly_we[0] <= w_rd_en;
      r_dly_a0[0] <= w_rd_en ? r_j : '0;
      r_dly_a1[0] <= w_rd_en ? w_partner : '0;
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_k <= r_k + 1'b1;
            if (w_last_k) begin
              r_k          <= '0;
              r_j          <= '0;
              r_s          <= '0;
              r_tw_conj    <= i_inverse;
              r_input_done <= 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          r_j   <= r_j + 1'b1;  // wraps to 0 for the next stage
          r_lat <= '0;
        end
        S_GAP: begin
          r_lat <= r_lat + 1'b1;
          if (r_lat == 3'(PIPE_LAT - 1)) begin
            r_lat <= '0;
            r_s   <= r_s + 1'b1;
            r_j   <= '0;
          end
        end
        S_FLUSH: begin
          r_lat <= r_lat + 1'b1;
          if (r_lat == 3'(PIPE_LAT - 1)) begin
            r_lat          <= '0;
            r_k            <= '0;
            r_rd_all       <= 1'b0;
            r_out_valid    <= 1'b0;
            r_output_start <= 1'b1;
          end
        end
        S_UNLOAD: begin
          if (w_issue) begin
            r_out_valid <= 1'b1;
            if (w_last_k) r_rd_all <= 1'b1;
            else          r_k      <= r_k + 1'b1;
          end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
          end
          if (w_last_hs) begin
            r_out_valid    <= 1'b0;
            r_input_done   <= 1'b0;
            r_output_start <= 1'b0;
            r_rd_all       <= 1'b0;
            r_k            <= '0;
            r_s            <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_out_valid    = r_out_valid;
  assign o_stage        = r_s;
  assign o_tw_conj      = r_tw_conj;
  assign o_input_done   = r_input_done;
  assign o_output_start = r_output_start;
  assign o_done         = r_done;
endmodule

// File: tb/tb_fft_inplace_ctrl.sv
// tb/tb_fft_inplace_ctrl.sv - bench for fft_inplace_ctrl with bank RAM and butterfly environment
module tb_fft_inplace_ctrl;
  localparam int LOG2N    = 6;
  localparam int PIPE_LAT = 1;
  localparam int A        = LOG2N - 1;
  localparam int N        = 1 << LOG2N;
  localparam int H        = 1 << A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, inverse = 1'b0, out_ready = 1'b0;
  logic o_in_ready, o_out_valid, o_re_b0, o_re_b1, o_we_b0, o_we_b1;
  logic o_bank_select, o_tw_conj, o_input_done, o_output_start, o_done;
  logic [A-1:0] o_raddr_b0, o_raddr_b1, o_waddr_b0, o_waddr_b1, o_tw_addr;
  logic [3:0]   o_stage;

  always #5 clk = ~clk;

  fft_inplace_ctrl #(.LOG2N(LOG2N), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(o_in_ready),
    .i_inverse(inverse), .i_out_ready(out_ready), .o_out_valid(o_out_valid),
    .o_raddr_b0(o_raddr_b0), .o_raddr_b1(o_raddr_b1),
    .o_waddr_b0(o_waddr_b0), .o_waddr_b1(o_waddr_b1),
    .o_re_b0(o_re_b0), .o_re_b1(o_re_b1), .o_we_b0(o_we_b0), .o_we_b1(o_we_b1),
    .o_bank_select(o_bank_select), .o_stage(o_stage), .o_tw_addr(o_tw_addr),
    .o_tw_conj(o_tw_conj), .o_input_done(o_input_done),
    .o_output_start(o_output_start), .o_done(o_done)
  );

  typedef struct {
    logic [31:0] d0, d1;
    int a0, a1, t;
  } wr_t;

  int nchk = 0, nerr = 0, cyc = 0;
  int lk, rcnt, ucnt, hcnt, ccyc, ndone, last_hs;
  bit load_done, exp_conj;
  logic [31:0] bank0 [H];
  logic [31:0] bank1 [H];
  logic [31:0] xin [N];
  logic [31:0] refv [N];
  logic [31:0] odata, in_data;
  wr_t wq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit par(input int v);
    logic [LOG2N-1:0] b;
    b = v[LOG2N-1:0];
    return ^b;
  endfunction

  // Flat-array reference: stage s combines x[k] (even parity) with x[k ^ 2^(LOG2N-1-s)].
  task automatic build_ref();
    int q, d, tw;
    logic [31:0] a, b;
    for (int i = 0; i < N; i++) refv[i] = xin[i];
    for (int s = 0; s < LOG2N - 1; s++) begin
      d = 1 << (A - 1 - s);
      for (int k = 0; k < N; k++) begin
        if (!par(k)) begin
          q  = k ^ (1 << (LOG2N - 1 - s));
          a  = refv[k];
          b  = refv[q];
          tw = ((k >> 1) % d) << s;
          refv[k] = a + b + 32'(tw);
          refv[q] = a - 3 * b;
        end
      end
    end
  endtask

  task automatic mon();
    logic p;
    int s, j, d;
    logic [31:0] a, b;
    wr_t e;
    if (o_done) begin
      ndone++;
      chk("done_after_hs", cyc, last_hs + 1);
      chk("done_in_ready", o_in_ready, 1);
    end
    if (o_in_ready) begin
      if (in_valid) begin
        p = par(lk);
        chk("ld_bank", o_bank_select, p);
        chk("ld_we", {o_we_b1, o_we_b0}, p ? 2 : 1);
        chk("ld_waddr0", o_waddr_b0, lk >> 1);
        chk("ld_waddr1", o_waddr_b1, lk >> 1);
        if (o_we_b0) bank0[o_waddr_b0] = in_data;
        if (o_we_b1) bank1[o_waddr_b1] = in_data;
        xin[lk] = in_data;
        if (lk == N - 1) begin
          exp_conj = inverse;
          build_ref();
          load_done = 1;
          rcnt = 0; ccyc = 0; ucnt = 0; hcnt = 0;
          wq.delete();
        end
        lk++;
      end else begin
        chk("ld_idle_we", {o_we_b1, o_we_b0}, 0);
      end
    end else if (!o_output_start) begin
      ccyc++;
      if (o_re_b0 | o_re_b1) begin
        chk("cp_read_in_range", rcnt < (LOG2N - 1) * H, 1);
        if (rcnt < (LOG2N - 1) * H) begin
          s = rcnt / H; j = rcnt % H; d = 1 << (A - 1 - s);
          chk("cp_re", {o_re_b1, o_re_b0}, 3);
          chk("cp_raddr0", o_raddr_b0, j);
          chk("cp_raddr1", o_raddr_b1, j ^ d);
          chk("cp_tw", o_tw_addr, (j % d) << s);
          chk("cp_stage", o_stage, s);
          chk("cp_input_done", o_input_done, 1);
          a = bank0[o_raddr_b0];
          b = bank1[o_raddr_b1];
          e.d0 = a + b + 32'(o_tw_addr);
          e.d1 = a - 3 * b;
          e.a0 = j; e.a1 = j ^ d; e.t = cyc;
          wq.push_back(e);
        end
        rcnt++;
      end
      if (o_we_b0 | o_we_b1) begin
        chk("cp_we", {o_we_b1, o_we_b0}, 3);
        chk("cp_wr_pending", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          chk("cp_wlat", cyc - e.t, PIPE_LAT);
          chk("cp_waddr0", o_waddr_b0, e.a0);
          chk("cp_waddr1", o_waddr_b1, e.a1);
          bank0[o_waddr_b0] = e.d0;
          bank1[o_waddr_b1] = e.d1;
        end
      end
    end else begin
      if (o_out_valid && out_ready) begin
        chk("un_hs_count", hcnt < N, 1);
        if (hcnt < N) chk("un_data", odata, refv[hcnt]);
        hcnt++;
        last_hs = cyc;
      end
      if (ucnt < N && (!o_out_valid || out_ready))
        chk("un_issue", o_re_b0 | o_re_b1, 1);
      if (o_re_b0 | o_re_b1) begin
        p = par(ucnt);
        chk("un_stall_rule", !o_out_valid || out_ready, 1);
        chk("un_re", {o_re_b1, o_re_b0}, p ? 2 : 1);
        chk("un_bank", o_bank_select, p);
        chk("un_raddr", p ? o_raddr_b1 : o_raddr_b0, ucnt >> 1);
        odata = o_bank_select ? bank1[o_raddr_b1] : bank0[o_raddr_b0];
        ucnt++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (rst_n) mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_mon();
    lk = 0; rcnt = 0; ucnt = 0; hcnt = 0; ccyc = 0; ndone = 0; last_hs = -10;
    load_done = 0;
    wq.delete();
  endtask

  task automatic load_frame(input bit gap);
    int t;
    lk = 0; load_done = 0; ndone = 0; t = 0;
    while (!load_done && t < 4 * N) begin
      in_valid = gap ? (t % 3 != 2) : 1'b1;
      in_data  = $urandom;
      inverse  = 1'($urandom_range(0, 1));
      cycle();
      t++;
    end
    in_valid = 0;
    chk("load_cycles", t, gap ? N + (N - 1) / 2 : N);
    chk("cp_entry_in_ready", o_in_ready, 0);
    chk("tw_conj", o_tw_conj, exp_conj);
    chk("input_done_set", o_input_done, 1);
  endtask

  task automatic drain(input bit rnd);
    int t;
    logic [3:0] pat;
    pat = 4'b1001;
    t = 0;
    while (ndone == 0 && t < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : pat[t % 4];
      cycle();
      t++;
    end
    chk("frame_done_seen", ndone, 1);
    chk("comp_cycles", ccyc, (LOG2N - 1) * (H + PIPE_LAT));
    chk("comp_reads", rcnt, (LOG2N - 1) * H);
    chk("wq_empty", wq.size(), 0);
    chk("outputs", hcnt, N);
    chk("input_done_clear", o_input_done, 0);
    chk("output_start_clear", o_output_start, 0);
    out_ready = 0;
    cycle();
    cycle();
    chk("done_once", ndone, 1);
  endtask

  initial begin
    int t;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", o_in_ready, 1);
    chk("rst_flags", {o_we_b0, o_we_b1, o_re_b0, o_re_b1, o_out_valid, o_done,
                      o_input_done, o_output_start, o_tw_conj, o_bank_select}, 0);
    chk("rst_stage", o_stage, 0);
    chk("rst_addr", {o_raddr_b0, o_raddr_b1, o_waddr_b0, o_waddr_b1, o_tw_addr}, 0);
    rst_n = 1;
    cycle();
    chk("post_rst_in_ready", o_in_ready, 1);

    load_frame(0);
    drain(0);

    load_frame(0);
    t = 0;
    while (rcnt < 2 * H + 10 && t < 1000) begin
      cycle();
      t++;
    end
    chk("mid_reached", rcnt, 2 * H + 10);
    chk("mid_stage", o_stage, 2);
    chk("mid_j", o_raddr_b0, 10);
    rst_n = 0;
    #1;
    chk("mid_rst_en", {o_we_b0, o_we_b1, o_re_b0, o_re_b1}, 0);
    chk("mid_rst_in_ready", o_in_ready, 1);
    @(negedge clk);
    chk("mid_rst_edge_en", {o_we_b0, o_we_b1, o_re_b0, o_re_b1, o_input_done}, 0);
    chk("mid_rst_edge_stage", o_stage, 0);
    clear_mon();
    @(posedge clk);
    #1;
    rst_n = 1;

    load_frame(1);
    drain(1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
